// File: rtl/bram_arbiter_if.sv
// Bundle of the two requester ports and the BRAM port of bram_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface bram_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  i_req0;
    logic                  i_req1;
    logic                  i_we0;
    logic                  i_we1;
    logic [ADDR_WIDTH-1:0] i_addr0;
    logic [ADDR_WIDTH-1:0] i_addr1;
    logic [DATA_WIDTH-1:0] i_wdata0;
    logic [DATA_WIDTH-1:0] i_wdata1;
    logic                  o_ack0;
    logic                  o_ack1;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic                  o_busy;
    logic                  o_bram_wr_en;
    logic [ADDR_WIDTH-1:0] o_bram_waddr;
    logic [DATA_WIDTH-1:0] o_bram_wdata;
    logic                  o_bram_rd_en;
    logic [ADDR_WIDTH-1:0] o_bram_raddr;
    logic [DATA_WIDTH-1:0] i_bram_rdata;

    modport slave (
        input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1,
               i_wdata0, i_wdata1, i_bram_rdata,
        output o_ack0, o_ack1, o_rdata, o_busy,
               o_bram_wr_en, o_bram_waddr, o_bram_wdata,
               o_bram_rd_en, o_bram_raddr
    );

    modport master (
        output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1,
               i_wdata0, i_wdata1, i_bram_rdata,
        input  o_ack0, o_ack1, o_rdata, o_busy,
               o_bram_wr_en, o_bram_waddr, o_bram_wdata,
               o_bram_rd_en, o_bram_raddr
    );
endinterface

// File: rtl/bram_arbiter.sv
// Two-port arbiter in front of a simple dual-port BRAM.
// Each access takes IDLE -> ACCESS -> DONE; the BRAM enables are high in
// ACCESS only and the granted requester's ack is high in DONE.
// Ties are round-robin by default; defining BRAM_ARB_FIXED_PRIORITY_EN
// makes port 0 always win a tie and removes the last-grant pointer.
module bram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    bram_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;   // 0: port 0, 1: port 1
    logic                  pick;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
`ifndef BRAM_ARB_FIXED_PRIORITY_EN
    logic                  last_q, last_d;
`endif

    // Arbitration: which port would be granted if the FSM left IDLE now
    always_comb begin
        pick = 1'b0;
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
        pick = bus.i_req1 & ~bus.i_req0;
`else
        // A lone request wins; on a tie the port not granted last wins
        pick = bus.i_req1 & (~bus.i_req0 | ~last_q);
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        wdata_d = wdata_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
`ifndef BRAM_ARB_FIXED_PRIORITY_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.i_req0 || bus.i_req1) begin
                    state_d = ACCESS;
                    grant_d = pick;
`ifndef BRAM_ARB_FIXED_PRIORITY_EN
                    last_d  = pick;
`endif
                    // Command is captured here so a requester dropping its
                    // request mid-transaction cannot disturb the access
                    if (pick) begin
                        wr_en_d = bus.i_we1;
                        rd_en_d = ~bus.i_we1;
                        waddr_d = bus.i_addr1;
                        raddr_d = bus.i_addr1;
                        wdata_d = bus.i_wdata1;
                    end else begin
                        wr_en_d = bus.i_we0;
                        rd_en_d = ~bus.i_we0;
                        waddr_d = bus.i_addr0;
                        raddr_d = bus.i_addr0;
                        wdata_d = bus.i_wdata0;
                    end
                end
            end
            ACCESS: begin
                state_d = DONE;
                ack0_d  = ~grant_q;
                ack1_d  = grant_q;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; async reset kills enables and acks at once
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            waddr_q <= '0;
            raddr_q <= '0;
            wdata_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            wdata_q <= wdata_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

`ifndef BRAM_ARB_FIXED_PRIORITY_EN
    // Last-grant pointer; resets to 1 so port 0 wins the first tie
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign bus.o_ack0       = ack0_q;
    assign bus.o_ack1       = ack1_q;
    assign bus.o_rdata      = bus.i_bram_rdata;
    assign bus.o_busy       = (state_q != IDLE);
    assign bus.o_bram_wr_en = wr_en_q;
    assign bus.o_bram_rd_en = rd_en_q;
    assign bus.o_bram_waddr = waddr_q;
    assign bus.o_bram_raddr = raddr_q;
    assign bus.o_bram_wdata = wdata_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter with a behavioural BRAM model.
module tb_bram_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
    localparam int TIE_B = 0;   // port that wins a tie when pointer points at 0
    localparam bit RR    = 1'b0;
`else
    localparam int TIE_B = 1;
    localparam bit RR    = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // BRAM model: synchronous write, registered read
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.o_bram_wr_en) mem[bus.o_bram_waddr] <= bus.o_bram_wdata;
        if (bus.o_bram_rd_en) bus.i_bram_rdata <= mem[bus.o_bram_raddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          port;
        int          due;
        bit          chk_rd;
        logic [DW-1:0] rdata;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    typedef struct {
        bit            r0;
        bit            we0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        bit            r1;
        bit            we1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        int            first;
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
    } vec_t;
    vec_t vt [10];
    vec_t v;

    int last_m = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every ack is matched against the scoreboard head
    always @(negedge clk) begin
        if (bus.o_ack0 === 1'b1 || bus.o_ack1 === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: ack0=%0b ack1=%0b cycle %0d, required no ack",
                         bus.o_ack0, bus.o_ack1, cyc);
            end else begin
                mon_e = sbq.pop_front();
                if ((bus.o_ack0 && bus.o_ack1) || (bus.o_ack1 != (mon_e.port == 1))
                    || cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL ack: ack0=%0b ack1=%0b cycle %0d, required port %0d at cycle %0d",
                             bus.o_ack0, bus.o_ack1, cyc, mon_e.port, mon_e.due);
                end
                if (mon_e.chk_rd) begin
                    checks++;
                    if (bus.o_rdata !== mon_e.rdata) begin
                        errors++;
                        $display("FAIL rdata: got %0h required %0h (port %0d cycle %0d)",
                                 bus.o_rdata, mon_e.rdata, mon_e.port, cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int port, input int due, input bit rd, input logic [DW-1:0] d);
        exp_t e;
        e.port = port; e.due = due; e.chk_rd = rd; e.rdata = d;
        sbq.push_back(e);
    endtask

    task automatic drop(input int port);
        if (port == 0) bus.i_req0 = 1'b0;
        else           bus.i_req1 = 1'b0;
    endtask

    // Drive one table entry from an IDLE cycle; each request is released
    // right after its ack so it is not re-arbitrated
    task automatic apply_vec(input vec_t x, input int idx);
        int k;
        int sec;
        k = cyc;
        bus.i_we0 = x.we0; bus.i_addr0 = x.a0; bus.i_wdata0 = x.d0;
        bus.i_we1 = x.we1; bus.i_addr1 = x.a1; bus.i_wdata1 = x.d1;
        bus.i_req0 = x.r0; bus.i_req1 = x.r1;
        sec = 1 - x.first;
        push(x.first, k + 2, (x.first == 0) ? !x.we0 : !x.we1,
             (x.first == 0) ? x.rd0 : x.rd1);
        if (x.r0 && x.r1)
            push(sec, k + 5, (sec == 0) ? !x.we0 : !x.we1, (sec == 0) ? x.rd0 : x.rd1);
        repeat (3) tick();
        drop(x.first);
        last_m = x.first;
        if (x.r0 && x.r1) begin
            repeat (3) tick();
            drop(sec);
            last_m = sec;
        end
        chk($sformatf("vec%0d_drained", idx), sbq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_req0 = 1'b0; bus.i_req1 = 1'b0;
        bus.i_we0 = 1'b0; bus.i_we1 = 1'b0;
        bus.i_addr0 = '0; bus.i_addr1 = '0;
        bus.i_wdata0 = '0; bus.i_wdata1 = '0;

        //           r0 we0 a0      d0          r1 we1 a1      d1          first  rd0         rd1
        vt[0] = '{1'b1, 1'b1, 8'd7,   16'h0005, 1'b0, 1'b0, 8'd0,   16'h0000, 0,     16'h0000, 16'h0000};
        vt[1] = '{1'b1, 1'b0, 8'd7,   16'h0000, 1'b0, 1'b0, 8'd0,   16'h0000, 0,     16'h0005, 16'h0000};
        vt[2] = '{1'b0, 1'b0, 8'd0,   16'h0000, 1'b1, 1'b1, 8'd3,   16'h0011, 1,     16'h0000, 16'h0000};
        vt[3] = '{1'b1, 1'b1, 8'd3,   16'h00AA, 1'b1, 1'b0, 8'd3,   16'h0000, 0,     16'h0000, 16'h00AA};
        vt[4] = '{1'b0, 1'b0, 8'd0,   16'h0000, 1'b1, 1'b1, 8'd9,   16'hBEEF, 1,     16'h0000, 16'h0000};
        vt[5] = '{1'b1, 1'b1, 8'd10,  16'h0F0F, 1'b0, 1'b0, 8'd0,   16'h0000, 0,     16'h0000, 16'h0000};
        vt[6] = '{1'b1, 1'b0, 8'd9,   16'h0000, 1'b1, 1'b0, 8'd10,  16'h0000, TIE_B, 16'hBEEF, 16'h0F0F};
        vt[7] = '{1'b1, 1'b1, 8'd255, 16'hFFFF, 1'b1, 1'b1, 8'd0,   16'h8001, TIE_B, 16'h0000, 16'h0000};
        vt[8] = '{1'b1, 1'b0, 8'd0,   16'h0000, 1'b1, 1'b0, 8'd255, 16'h0000, TIE_B, 16'h8001, 16'hFFFF};
        vt[9] = '{1'b0, 1'b0, 8'd0,   16'h0000, 1'b1, 1'b0, 8'd3,   16'h0000, 1,     16'h0000, 16'h00AA};

        // Reset state
        #1;
        chk("rst_busy",   bus.o_busy, 0);
        chk("rst_ack0",   bus.o_ack0, 0);
        chk("rst_ack1",   bus.o_ack1, 0);
        chk("rst_wr_en",  bus.o_bram_wr_en, 0);
        chk("rst_rd_en",  bus.o_bram_rd_en, 0);
        chk("rst_waddr",  bus.o_bram_waddr, 0);
        chk("rst_raddr",  bus.o_bram_raddr, 0);
        chk("rst_wdata",  bus.o_bram_wdata, 0);
        repeat (2) tick();
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply_vec(vt[i], i);
        end

        // Reset pulsed during ACCESS of a write: no commit, no ack
        begin
            int k;
            k = cyc;
            bus.i_we0 = 1'b1; bus.i_addr0 = 8'd9; bus.i_wdata0 = 16'h1234;
            bus.i_req0 = 1'b1;
            tick();
            chk("acc_busy",  bus.o_busy, 1);
            chk("acc_wr_en", bus.o_bram_wr_en, 1);
            chk("acc_rd_en", bus.o_bram_rd_en, 0);
            chk("acc_waddr", bus.o_bram_waddr, 9);
            chk("acc_wdata", bus.o_bram_wdata, 16'h1234);
            #2;
            rst_n = 1'b0;
            #1;
            chk("rstacc_wr_en", bus.o_bram_wr_en, 0);
            chk("rstacc_busy",  bus.o_busy, 0);
            chk("rstacc_waddr", bus.o_bram_waddr, 0);
            chk("rstacc_wdata", bus.o_bram_wdata, 0);
            bus.i_req0 = 1'b0;
            tick();
            rst_n = 1'b1;
            last_m = 1;
            repeat (3) tick();
            v = '{1'b1, 1'b0, 8'd9, 16'h0000, 1'b0, 1'b0, 8'd0, 16'h0000, 0, 16'hBEEF, 16'h0000};
            apply_vec(v, 10);
        end

        // Reset asserted during DONE: the ack must vanish
        begin
            bus.i_we1 = 1'b1; bus.i_addr1 = 8'd20; bus.i_wdata1 = 16'h5555;
            bus.i_req1 = 1'b1;
            repeat (2) tick();
            rst_n = 1'b0;
            #1;
            chk("rstdone_ack1", bus.o_ack1, 0);
            chk("rstdone_busy", bus.o_busy, 0);
            bus.i_req1 = 1'b0;
            tick();
            rst_n = 1'b1;
            last_m = 1;
            repeat (3) tick();
        end

        // Both requests held continuously for four accesses
        begin
            int k;
            int g;
            k = cyc;
            bus.i_we0 = 1'b0; bus.i_addr0 = 8'd7;
            bus.i_we1 = 1'b0; bus.i_addr1 = 8'd10;
            bus.i_req0 = 1'b1; bus.i_req1 = 1'b1;
            for (int i = 0; i < 4; i++) begin
                g = (RR && last_m == 0) ? 1 : 0;
                push(g, k + 2 + 3 * i, 1'b1, (g == 1) ? 16'h0F0F : 16'h0005);
                last_m = g;
            end
            repeat (12) tick();
            bus.i_req0 = 1'b0; bus.i_req1 = 1'b0;
            tick();
            chk("cont_drained", sbq.size(), 0);
        end

        // Port 1 holds its request one cycle past the ack: second access
        begin
            int k;
            repeat (2) tick();
            k = cyc;
            bus.i_we1 = 1'b0; bus.i_addr1 = 8'd3;
            bus.i_req1 = 1'b1;
            push(1, k + 2, 1'b1, 16'h00AA);
            push(1, k + 5, 1'b1, 16'h00AA);
            repeat (4) tick();
            bus.i_req1 = 1'b0;
            repeat (3) tick();
            chk("hold_drained", sbq.size(), 0);
            chk("hold_idle", bus.o_busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
